phy_rx_fifo_arbiter: RTL and testbench
======================================

Name: phy_rx_fifo_arbiter

Overview:
Round-robin write-side arbiter and buffer controller for the PHY receive path. It shares one synchronous FIFO store among NUM_REQ requesters, such as per-lane symbol producers. Each accepted word is tagged with its source index. Entries drain to a single downstream consumer over a valid/ready interface with first-word-fall-through timing.

Parameters:
NUM_REQ, 4, number of requesters; must be ≥2.
DATA_WIDTH, 8, payload width per requester.
DEPTH, 8, FIFO entries; must be a power of two ≥2; all DEPTH entries are usable.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
s_valid_i  in  NUM_REQ  per-requester valid
s_data_i  in  NUM_REQ*DATA_WIDTH  flattened payloads; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
s_ready_o  out  NUM_REQ  one-hot grant/accept
m_valid_o  out  1  head entry valid
m_data_o  out  DATA_WIDTH  head payload
m_src_o  out  $clog2(NUM_REQ)  head source index
m_ready_i  in  1  consumer accept
level_o  out  $clog2(DEPTH+1)  current occupancy
full_o  out  1  level_o == DEPTH
empty_o  out  1  level_o == 0

Behaviour:
- Reset (rst_i high at a clock edge):
  - Write/read pointers, count and rr_ptr are cleared to 0.
  - In the cycle after reset, all outputs are 0 and empty_o is 1.
  - Reset mid-operation discards all stored entries. There is no flush handshake.
- Arbitration (combinational from registered state):
  - If full_o is 0, grant goes to the first i with s_valid_i[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - s_ready_o is one-hot or zero, and is zero whenever full_o is 1.
  - s_ready_o may depend on s_valid_i.
- Transfer rule: a write occurs when s_valid_i[g] & s_ready_o[g]. It stores {g, s_data_i[g]} at the write pointer, and the write pointer increments with natural wrap.
- Pointer update: after a write, rr_ptr <= (g+1) mod NUM_REQ. With no write, rr_ptr holds.
- Fairness: any continuously asserted requester is granted within NUM_REQ write cycles.
- Requester protocol: requesters hold valid and data stable until accepted. Dropping valid before acceptance is legal, and that word is lost to the arbiter.
- Read side:
  - m_valid_o = !empty_o.
  - m_data_o and m_src_o present the entry at the read pointer combinationally, and are forced to 0 when m_valid_o is 0.
  - A pop occurs on m_valid_o & m_ready_i; the read pointer increments with wrap.
- Latency: a word accepted at edge N appears on m_valid_o/m_data_o after edge N, i.e. in cycle N+1. There is no same-cycle bypass when empty.
- Count: level_o += write − pop, evaluated with simultaneous events:
  - Full plus pop: no write that cycle, because ready is derived from registered full. Level becomes DEPTH−1.
  - Empty plus write: no pop possible. Level becomes 1.
  - Write and pop in the same cycle at intermediate level: level unchanged.
- Overflow and underflow are impossible by construction. The bench asserts level_o ≤ DEPTH.

Decomposition:
- Package phy_rx_arb_pkg:
  - Default-parameter constants.
  - Function idx_w(n) returning max(1, $clog2(n)).
  - Typedef-free entry layout helper: constant SRC_LSB = DATA_WIDTH, documented as {src, data}.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req, enable, advance.
  - Outputs: one-hot gnt and gnt_idx.
  - Holds the rr_ptr register.
- Top level holds storage, pointers, count and read-side logic.

Test Plan:
- Reset then idle → level_o=0, empty_o=1, m_valid_o=0, s_ready_o=0, m_data_o=0.
- Req0 alone sends 0x11 with m_ready_i=0 → s_ready_o=4'b0001 in cycle 0; m_valid_o=1, m_data_o=0x11, m_src_o=0, level_o=1 in cycle 1.
- All four valid continuously, data=0xA0+i, m_ready_i=0 → grants 0,1,2,3,0,1,2,3. Full after 8 writes (full_o=1, s_ready_o=0). Drain order: src 0,1,2,3,0,1,2,3.
- Full FIFO, m_ready_i=1 and all valid for one cycle → pop without write, level_o=7. Next cycle a write plus pop leaves level_o=7.
- Empty FIFO, req2 writes 0x5C while m_ready_i=1 → no pop that cycle; next cycle m_data_o=0x5C pops and level_o returns to 0.
- rst_i asserted with level_o=5 → next cycle level_o=0, m_valid_o=0, rr_ptr=0. The first grant after reset with all valid goes to req0.

Source files
------------

// File: rtl/phy_rx_arb_pkg.sv
// Shared constants and helpers for the PHY receive round-robin FIFO arbiter.
// A stored entry is laid out as {src, data}; the source index starts at bit SRC_LSB.
package phy_rx_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 8;

  // Bit position of the source index inside an entry {src, data}
  localparam int unsigned SRC_LSB = DEF_DATA_WIDTH;

  // Index width that never collapses to zero bits
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phy_rx_fifo_arbiter_rr_arbiter.sv
// Round-robin grant generator; the search starts at rr_ptr and rr_ptr moves
// past the winner whenever a grant is actually used.
module rr_arbiter
  import phy_rx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // First requester at or after rr_ptr, modulo NUM_REQ
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && enable && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/phy_rx_fifo_arbiter.sv
// Shared receive FIFO: round-robin write arbitration across NUM_REQ requesters,
// source-tagged entries and a first-word-fall-through valid/ready read port.
module phy_rx_fifo_arbiter
  import phy_rx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            s_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data_i,
  output logic [NUM_REQ-1:0]            s_ready_o,
  output logic                          m_valid_o,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  output logic [$clog2(NUM_REQ)-1:0]    m_src_o,
  input  logic                          m_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]    level_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int unsigned IDX_W         = idx_w(NUM_REQ);
  localparam int unsigned AW            = $clog2(DEPTH);
  localparam int unsigned LW            = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_SRC_LSB = DATA_WIDTH;
  localparam int unsigned EW            = IDX_W + DATA_WIDTH;

  logic [EW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         count;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [EW-1:0]         head;
  logic                  wr;
  logic                  rd;

  assign full_o  = (count == LW'(DEPTH));
  assign empty_o = (count == '0);

  // Ready comes from registered fullness only, so a full FIFO never writes
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (s_valid_i),
    .enable  (!full_o),
    .advance (wr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign s_ready_o = gnt;
  assign wr        = |(gnt & s_valid_i);
  assign rd        = m_valid_o && m_ready_i;

  always_comb begin
    wr_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        wr_data = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Storage is not reset; validity is tracked by count alone
  always_ff @(posedge clk_i) begin
    if (wr) begin
      mem[wr_ptr] <= {gnt_idx, wr_data};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr && !rd) begin
        count <= count + LW'(1);
      end else if (!wr && rd) begin
        count <= count - LW'(1);
      end
    end
  end

  // Head entry falls through; payload and source are zeroed while empty
  assign head      = mem[rd_ptr];
  assign m_valid_o = !empty_o;
  assign m_data_o  = m_valid_o ? head[ENTRY_SRC_LSB-1:0] : '0;
  assign m_src_o   = m_valid_o ? head[EW-1:ENTRY_SRC_LSB] : '0;
  assign level_o   = count;

endmodule

// File: tb/tb_phy_rx_fifo_arbiter.sv
// Directed bench for phy_rx_fifo_arbiter: a table of per-cycle vectors plus
// hand-written reset and rotation sequences.
module tb_phy_rx_fifo_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  s_valid_i;
  logic [31:0] s_data_i;
  logic [3:0]  s_ready_o;
  logic        m_valid_o;
  logic [7:0]  m_data_o;
  logic [1:0]  m_src_o;
  logic        m_ready_i;
  logic [3:0]  level_o;
  logic        full_o;
  logic        empty_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  phy_rx_fifo_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .DEPTH      (8)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_valid_i (s_valid_i),
    .s_data_i  (s_data_i),
    .s_ready_o (s_ready_o),
    .m_valid_o (m_valid_o),
    .m_data_o  (m_data_o),
    .m_src_o   (m_src_o),
    .m_ready_i (m_ready_i),
    .level_o   (level_o),
    .full_o    (full_o),
    .empty_o   (empty_o)
  );

  typedef struct {
    logic        rst;
    logic        chk;
    logic [3:0]  v;
    logic [31:0] d;
    logic        mr;
    logic [3:0]  rdy;
    logic        mv;
    logic [7:0]  md;
    logic [1:0]  src;
    logic [3:0]  lvl;
    logic        full;
    logic        empty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic chk, input logic [3:0] v,
                              input logic [31:0] d, input logic mr, input logic [3:0] rdy,
                              input logic mv, input logic [7:0] md, input logic [1:0] src,
                              input logic [3:0] lvl, input logic full, input logic empty);
    vec_t r;
    r.rst = rst; r.chk = chk; r.v = v; r.d = d; r.mr = mr; r.rdy = rdy;
    r.mv = mv; r.md = md; r.src = src; r.lvl = lvl; r.full = full; r.empty = empty;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs away from the rising edge, then sample settled outputs
  task automatic drive(input logic rst, input logic [3:0] v, input logic [31:0] d, input logic mr);
    @(negedge clk_i);
    rst_i     = rst;
    s_valid_i = v;
    s_data_i  = d;
    m_ready_i = mr;
    #1;
  endtask

  task automatic check_vec(input vec_t e, input string tag);
    chk({tag, " s_ready"}, int'(s_ready_o), int'(e.rdy));
    chk({tag, " m_valid"}, int'(m_valid_o), int'(e.mv));
    chk({tag, " m_data"},  int'(m_data_o),  int'(e.md));
    chk({tag, " m_src"},   int'(m_src_o),   int'(e.src));
    chk({tag, " level"},   int'(level_o),   int'(e.lvl));
    chk({tag, " full"},    int'(full_o),    int'(e.full));
    chk({tag, " empty"},   int'(empty_o),   int'(e.empty));
    chk({tag, " level_bound"}, int'(level_o <= 4'd8), 1);
  endtask

  initial begin
    logic [7:0] byte_a [4];
    byte_a[0] = 8'hA0; byte_a[1] = 8'hA1; byte_a[2] = 8'hA2; byte_a[3] = 8'hA3;

    // Single writer, pop latency, empty+write with ready high
    vecs.push_back(mk(0,1,4'h0,32'h0,0,        4'h0,0,8'h00,2'd0,4'd0,0,1));
    vecs.push_back(mk(0,1,4'h1,32'h11,0,       4'h1,0,8'h00,2'd0,4'd0,0,1));
    vecs.push_back(mk(0,1,4'h0,32'h0,0,        4'h0,1,8'h11,2'd0,4'd1,0,0));
    vecs.push_back(mk(0,1,4'h0,32'h0,1,        4'h0,1,8'h11,2'd0,4'd1,0,0));
    vecs.push_back(mk(0,1,4'h0,32'h0,0,        4'h0,0,8'h00,2'd0,4'd0,0,1));
    vecs.push_back(mk(0,1,4'h4,32'h005C0000,1, 4'h4,0,8'h00,2'd0,4'd0,0,1));
    vecs.push_back(mk(0,1,4'h0,32'h0,1,        4'h0,1,8'h5C,2'd2,4'd1,0,0));
    vecs.push_back(mk(0,1,4'h0,32'h0,0,        4'h0,0,8'h00,2'd0,4'd0,0,1));
    // Reset, then fill with all four requesters valid
    vecs.push_back(mk(1,0,4'h0,32'h0,0,        4'h0,0,8'h00,2'd0,4'd0,0,1));
    vecs.push_back(mk(0,1,4'hF,32'hA3A2A1A0,0, 4'h1,0,8'h00,2'd0,4'd0,0,1));
    for (int i = 1; i < 8; i++) begin
      vecs.push_back(mk(0,1,4'hF,32'hA3A2A1A0,0, 4'(1 << (i % 4)),1,8'hA0,2'd0,4'(i),0,0));
    end
    vecs.push_back(mk(0,1,4'hF,32'hA3A2A1A0,0, 4'h0,1,8'hA0,2'd0,4'd8,1,0));
    // Full plus pop, then write plus pop at level 7, then drain
    vecs.push_back(mk(0,1,4'hF,32'hA3A2A1A0,1, 4'h0,1,8'hA0,2'd0,4'd8,1,0));
    vecs.push_back(mk(0,1,4'hF,32'hA3A2A1A0,1, 4'h1,1,8'hA1,2'd1,4'd7,0,0));
    for (int i = 0; i < 7; i++) begin
      vecs.push_back(mk(0,1,4'h0,32'h0,1, 4'h0,1,byte_a[(i+2)%4],2'((i+2)%4),4'(7-i),0,0));
    end
    vecs.push_back(mk(0,1,4'h0,32'h0,0,        4'h0,0,8'h00,2'd0,4'd0,0,1));

    rst_i = 1'b1; s_valid_i = '0; s_data_i = '0; m_ready_i = 1'b0;
    drive(1, 4'h0, 32'h0, 0);
    drive(1, 4'h0, 32'h0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].mr);
      if (vecs[i].chk) check_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-operation at level 5
    for (int i = 0; i < 5; i++) drive(0, 4'hF, 32'hB3B2B1B0, 0);
    drive(0, 4'h0, 32'h0, 0);
    chk("pre_reset level", int'(level_o), 5);
    drive(1, 4'h0, 32'h0, 0);
    drive(0, 4'hF, 32'hC3C2C1C0, 1);
    chk("post_reset level", int'(level_o), 0);
    chk("post_reset m_valid", int'(m_valid_o), 0);
    chk("post_reset empty", int'(empty_o), 1);
    chk("post_reset m_data", int'(m_data_o), 0);
    chk("post_reset first_grant", int'(s_ready_o), 4'h1);

    // Continuous requesters with steady popping rotate one grant per cycle
    for (int k = 0; k < 8; k++) begin
      drive(0, 4'hF, 32'hC3C2C1C0, 1);
      chk($sformatf("rotate%0d s_ready", k), int'(s_ready_o), 1 << ((k + 1) % 4));
      chk($sformatf("rotate%0d m_src", k), int'(m_src_o), k % 4);
      chk($sformatf("rotate%0d m_data", k), int'(m_data_o), 8'hC0 + (k % 4));
      chk($sformatf("rotate%0d level", k), int'(level_o), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
